// File: rtl/vscale_bus_nslave.sv
// rtl/vscale_bus_nslave.sv - load/store master fanned out to NSLV address-decoded slaves
// Byte strobes, load alignment/extension, wait-state handshake and error responses.
module vscale_bus_nslave #(
    parameter int                   NSLV     = 3,
    parameter int                   ADDR_W   = 32,
    parameter int                   RGN_W    = 12,
    parameter logic [NSLV*RGN_W-1:0] SLV_BASE = {12'h200, 12'h001, 12'h000},
    parameter int                   SLV_AW   = 14,
    parameter int                   TIMEOUT  = 15
) (
    input  logic                 clk_i,
    input  logic                 reset,
    input  logic                 m_req,
    input  logic                 m_wen,
    input  logic [2:0]           m_size,
    input  logic [ADDR_W-1:0]    m_addr,
    input  logic [31:0]          m_wdata,
    output logic                 m_ready,
    output logic                 m_rvalid,
    output logic [31:0]          m_rdata,
    output logic                 m_err,
    output logic [NSLV-1:0]      s_req,
    output logic                 s_wen,
    output logic [SLV_AW-1:0]    s_addr,
    output logic [3:0]           s_wstrb,
    output logic [31:0]          s_wdata,
    input  logic [NSLV*32-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ack
);
    localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t              r_state, w_next;
    logic                r_wen;
    logic [2:0]          r_size;
    logic [SLV_AW+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [SEL_W-1:0]    r_sel;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_rdata;

    logic                w_hit, w_legal, w_ack, w_expired;
    logic [SEL_W-1:0]    w_dec_sel;
    logic [31:0]         w_word, w_shift, w_load;
    logic                w_unused_addr;

    assign w_unused_addr = ^m_addr;

    // Descending scan so the lowest matching index overrides the others.
    always_comb begin
        w_hit     = 1'b0;
        w_dec_sel = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (m_addr[ADDR_W-1 -: RGN_W] == SLV_BASE[i*RGN_W +: RGN_W]) begin
                w_hit     = 1'b1;
                w_dec_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_legal = 1'b0;
        case (m_size)
            3'd0, 3'd4: w_legal = 1'b1;
            3'd1, 3'd5: w_legal = ~m_addr[0];
            3'd2:       w_legal = (m_addr[1:0] == 2'b00);
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_ack     = s_ack[r_sel];
    assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_word    = s_rdata[r_sel*32 +: 32];
    assign w_shift   = w_word >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_size)
            3'd0:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd4:    w_load = {24'h0, w_shift[7:0]};
            3'd1:    w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'd5:    w_load = {16'h0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (m_req) w_next = (w_legal && w_hit) ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (w_ack || w_expired) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (m_req) begin
                    r_wen   <= m_wen;
                    r_size  <= m_size;
                    r_addr  <= m_addr[SLV_AW+1:0];
                    r_wdata <= m_wdata;
                    r_sel   <= w_dec_sel;
                    r_err   <= ~(w_legal & w_hit);
                    r_cnt   <= '0;
                    r_rdata <= '0;
                end
                ST_ACCESS: begin
                    // An ack in the expiry cycle still wins over the timeout.
                    if (w_ack) begin
                        r_rdata <= r_wen ? 32'h0 : w_load;
                        r_err   <= 1'b0;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign m_ready  = (r_state == ST_IDLE);
    assign m_rvalid = (r_state == ST_RESP);
    assign m_err    = m_rvalid & r_err;
    assign m_rdata  = r_rdata;
    assign s_req    = (r_state == ST_ACCESS) ? (NSLV'(1) << r_sel) : '0;
    assign s_wen    = r_wen;
    assign s_addr   = r_addr[SLV_AW+1:2];

    always_comb begin
        s_wstrb = 4'h0;
        s_wdata = r_wdata;
        case (r_size[1:0])
            2'd0: begin
                s_wstrb = 4'b0001 << r_addr[1:0];
                s_wdata = {4{r_wdata[7:0]}};
            end
            2'd1: begin
                s_wstrb = 4'b0011 << r_addr[1:0];
                s_wdata = {2{r_wdata[15:0]}};
            end
            default: s_wstrb = 4'hF;
        endcase
        if (!r_wen) s_wstrb = 4'h0;
    end
endmodule

// File: tb/tb_vscale_bus_nslave.sv
// tb/tb_vscale_bus_nslave.sv - directed and randomized checks of vscale_bus_nslave
module tb_vscale_bus_nslave;
    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        m_req = 1'b0;
    logic        m_wen = 1'b0;
    logic [2:0]  m_size = 3'd0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_ready, m_rvalid, m_err;
    logic [31:0] m_rdata;
    logic [2:0]  s_req;
    logic        s_wen;
    logic [13:0] s_addr;
    logic [3:0]  s_wstrb;
    logic [31:0] s_wdata;
    logic [95:0] s_rdata = 96'h0;
    logic [2:0]  s_ack = 3'b000;

    int errors = 0;
    int checks = 0;
    logic [11:0] bases [3] = '{12'h000, 12'h001, 12'h200};

    vscale_bus_nslave dut (
        .clk_i(clk_i), .reset(reset), .m_req(m_req), .m_wen(m_wen), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .m_err(m_err), .s_req(s_req), .s_wen(s_wen), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // waits: cycle index (from first s_req cycle) on which the slave acks; >= 15 never acks in time
    task automatic run_txn(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic [31:0] rword);
        int sel, off, exp_lat, got_lat, reqcyc;
        logic legal, exp_err, timed_out;
        logic [2:0] onehot;
        logic [31:0] exp_rdata, exp_wdata, sh, v;
        logic [3:0] exp_strb;
        sel = -1;
        for (int i = 0; i < 3; i++)
            if (sel < 0 && addr[31:20] == bases[i]) sel = i;
        off = int'(addr[1:0]);
        case (size)
            3'd0, 3'd4: legal = 1'b1;
            3'd1, 3'd5: legal = (off % 2 == 0);
            3'd2:       legal = (off == 0);
            default:    legal = 1'b0;
        endcase
        exp_err   = !legal || sel < 0;
        timed_out = !exp_err && waits >= 15;
        exp_lat   = exp_err ? 0 : (timed_out ? 15 : waits + 1);
        onehot    = (sel >= 0) ? 3'(1 << sel) : 3'b000;
        sh = rword >> (8 * off);
        case (size)
            3'd0, 3'd4: begin v = sh & 32'hFF;   if (size == 3'd0 && v > 127)   v = v | 32'hFFFFFF00; end
            3'd1, 3'd5: begin v = sh & 32'hFFFF; if (size == 3'd1 && v > 32767) v = v | 32'hFFFF0000; end
            default:    v = rword;
        endcase
        exp_rdata = (exp_err || timed_out || wen) ? 32'h0 : v;
        case (size)
            3'd0:    begin exp_strb = 4'(1 << off); exp_wdata = (wdata & 32'hFF) * 32'h01010101; end
            3'd1:    begin exp_strb = 4'(3 << off); exp_wdata = (wdata & 32'hFFFF) * 32'h00010001; end
            default: begin exp_strb = 4'hF;         exp_wdata = wdata; end
        endcase
        if (!wen) exp_strb = 4'h0;

        @(negedge clk_i);
        check("ready_idle", m_ready, 1);
        m_req = 1'b1; m_wen = wen; m_size = size; m_addr = addr; m_wdata = wdata;
        @(posedge clk_i);
        got_lat = -1;
        reqcyc  = 0;
        for (int c = 0; c < 40 && got_lat < 0; c++) begin
            @(negedge clk_i);
            m_req = 1'b0; m_addr = $urandom; m_wdata = $urandom;
            s_ack = 3'b000;
            if (m_rvalid) begin
                got_lat = c;
                check("m_err", m_err, exp_err || timed_out);
                check("m_rdata", m_rdata, exp_rdata);
                check("ready_resp", m_ready, 0);
            end else if (s_req != 3'b000) begin
                reqcyc++;
                if (reqcyc == 1) begin
                    check("s_req", s_req, onehot);
                    check("s_addr", s_addr, (addr >> 2) & 32'h3FFF);
                    check("s_wen", s_wen, wen);
                    check("s_wstrb", s_wstrb, exp_strb);
                    if (wen) check("s_wdata", s_wdata, exp_wdata);
                end
                s_rdata = {$urandom, $urandom, $urandom};
                if (sel >= 0) s_rdata[sel*32 +: 32] = rword;
                s_ack = 3'($urandom) & ~onehot;
                if (c == waits) s_ack = s_ack | onehot;
            end
        end
        check("latency", got_lat, exp_lat);
        check("req_cycles", reqcyc, exp_lat == 0 ? 0 : exp_lat);
    endtask

    initial begin
        logic [2:0] sz;
        logic [31:0] a;
        logic [11:0] rg;
        int r, w;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset = 1'b0;
        check("rst_ready", m_ready, 1);
        check("rst_rvalid", m_rvalid, 0);
        check("rst_err", m_err, 0);
        check("rst_rdata", m_rdata, 0);
        check("rst_sreq", s_req, 0);
        check("rst_swen", s_wen, 0);
        check("rst_wstrb", s_wstrb, 0);
        check("rst_saddr", s_addr, 0);
        check("rst_swdata", s_wdata, 0);

        run_txn(1'b0, 3'd2, 32'h00100008, 32'h0, 0, 32'hDEADBEEF);
        run_txn(1'b1, 3'd0, 32'h20000003, 32'h000000A5, 0, 32'h0);
        run_txn(1'b0, 3'd0, 32'h00100002, 32'h0, 3, 32'h80FF7F01);
        run_txn(1'b0, 3'd4, 32'h00100003, 32'h0, 3, 32'h80FF7F01);
        run_txn(1'b0, 3'd1, 32'h00100000, 32'h0, 3, 32'h80FF7F01);
        run_txn(1'b0, 3'd5, 32'h00100002, 32'h0, 1, 32'h80FF7F01);
        run_txn(1'b1, 3'd1, 32'h00000006, 32'h1234BEEF, 2, 32'h0);
        run_txn(1'b0, 3'd2, 32'h00100002, 32'h0, 0, 32'h0);
        run_txn(1'b0, 3'd2, 32'h30000000, 32'h0, 0, 32'h0);
        run_txn(1'b0, 3'd3, 32'h00000000, 32'h0, 0, 32'h0);
        run_txn(1'b0, 3'd2, 32'h00000000, 32'h0, 99, 32'h0);
        run_txn(1'b0, 3'd2, 32'h00000004, 32'h0, 14, 32'hCAFEF00D);

        // Abort a waiting access with reset, then confirm the bus still works.
        @(negedge clk_i);
        m_req = 1'b1; m_wen = 1'b0; m_size = 3'd2; m_addr = 32'h00100004;
        @(posedge clk_i);
        @(negedge clk_i);
        m_req = 1'b0;
        check("abort_sreq_on", s_req, 3'b010);
        repeat (2) @(negedge clk_i);
        reset = 1'b1;
        @(negedge clk_i);
        reset = 1'b0;
        check("abort_sreq", s_req, 0);
        check("abort_ready", m_ready, 1);
        check("abort_rvalid", m_rvalid, 0);
        run_txn(1'b0, 3'd2, 32'h00100004, 32'h0, 0, 32'h13579BDF);

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 3);
            rg = (r == 0) ? 12'h000 : (r == 1) ? 12'h001 : (r == 2) ? 12'h200 : 12'h3AB;
            a  = {rg, 20'($urandom)};
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 3'd2) a[1:0] = 2'b00;
                if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
            end
            r = $urandom_range(0, 9);
            w = (r == 9) ? 99 : (r == 8) ? 14 : r % 4;
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 3'd4) sz = 3'd0;
                if (sz == 3'd5) sz = 3'd1;
                run_txn(1'b1, sz, a, $urandom, w, $urandom);
            end else begin
                run_txn(1'b0, sz, a, 32'h0, w, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vscale_bus_nslave.md
# vscale_bus_nslave

Parametrised data-side bus for the vscale core: a single load/store master port fans out to NSLV address-decoded slaves. Each region is selected by comparing its base against the top RGN_W address bits. Compared with the fixed two-slave bus, this block adds:
- byte-strobe writes, so slaves need no read-modify-write;
- in-bus load alignment with sign or zero extension;
- a request/acknowledge handshake that tolerates slave wait states;
- error responses for decode miss, misalignment, illegal size and slave timeout.

## Interface
- NSLV, 3: number of slaves (1..8).
- ADDR_W, 32: master address width.
- RGN_W, 12: number of top address bits used for region decode.
- SLV_BASE, {12'h200,12'h001,12'h000}: packed bases; slave i base = SLV_BASE[i*RGN_W +: RGN_W].
- SLV_AW, 14: slave word-address width; s_addr = addr[SLV_AW+1:2].
- TIMEOUT, 15: maximum number of cycles s_req is held without s_ack before an error is returned.
- clk_i  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  1  master request.
- m_wen  in  1  1 = store, 0 = load.
- m_size  in  3  funct3 encoding: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU; 3, 6 and 7 are illegal.
- m_addr  in  ADDR_W  byte address.
- m_wdata  in  32  store data, right-aligned.
- m_ready  out  1  block can accept a request (high only in IDLE).
- m_rvalid  out  1  one-cycle completion pulse, for loads and stores alike.
- m_rdata  out  32  aligned and extended load data; 0 for stores and errors.
- m_err  out  1  qualifies m_rvalid as an error.
- s_req  out  NSLV  one-hot slave request.
- s_wen  out  1  store flag.
- s_addr  out  SLV_AW  word address.
- s_wstrb  out  4  byte strobes.
- s_wdata  out  32  lane-replicated store data.
- s_rdata  in  NSLV*32  per-slave read data, valid in the s_ack cycle.
- s_ack  in  NSLV  per-slave acknowledge.

## Operation
- State machine: IDLE, ACCESS, RESP.
- **IDLE**
  - m_ready = 1.
  - When m_req is high, latch wen, size, addr, wdata and the decode result.
  - If the request is legal and decodes to a slave: go to ACCESS.
  - Otherwise: go to RESP with the error flag set.
- **Decode**
  - Slave i is hit when m_addr[ADDR_W-1 -: RGN_W] == its base.
  - If several slaves match, the lowest index wins.
  - No match is a decode error.
- **Legality**
  - Size 3, 6 or 7 is an error.
  - H/HU with addr[0] = 1 is an error.
  - W with addr[1:0] != 0 is an error.
- **Write lanes**
  - B: s_wstrb = 4'b0001 << addr[1:0]; s_wdata = {4{wdata[7:0]}}.
  - H: s_wstrb = 4'b0011 << addr[1:0]; s_wdata = {2{wdata[15:0]}}.
  - W: s_wstrb = 4'hF; s_wdata = wdata.
  - For loads, s_wstrb = 0.
- **ACCESS**
  - s_req[sel] = 1; s_addr, s_wen, s_wstrb and s_wdata are held stable.
  - On s_ack[sel]: capture s_rdata[sel*32 +: 32], go to RESP.
  - Timeout counter starts at 0 on entry and increments each cycle without an ack.
  - If the counter reaches TIMEOUT-1 with no ack: drop s_req, go to RESP with error.
  - An ack and the timeout in the same cycle resolve as the ack (no error).
- **Load extract**
  - Shift the captured word right by 8*addr[1:0].
  - B and H sign-extend; BU and HU zero-extend; W passes through unchanged.
- **RESP**
  - m_rvalid = 1 for exactly one cycle, with m_err and m_rdata registered.
  - Next state is IDLE. The master cannot issue a new request in the RESP cycle (m_ready = 0).
- **Ignored acks**: s_ack on an unselected slave, or any s_ack outside ACCESS, is ignored.
- **Reset**
  - Asserting reset in any state returns the block to IDLE on that edge.
  - s_req drops, and any in-flight transaction is discarded with no response.

## Timing
- Reset values:
  - m_ready = 1 (IDLE).
  - m_rvalid, m_err, m_rdata = 0.
  - s_req = 0, s_wen = 0, s_wstrb = 0, s_addr = 0, s_wdata = 0.
  - Timeout counter = 0.
- Accept at edge T0. s_req is high from cycle T0+1.
- An ack in cycle T0+1+k gives m_rvalid in cycle T0+2+k. Minimum latency is 2 cycles; minimum throughput is one transaction per 3 cycles.
- An illegal request or decode miss gives m_rvalid & m_err in cycle T0+1, and no s_req is ever asserted.
- Timeout: s_req is high for exactly TIMEOUT cycles, then m_rvalid & m_err in the following cycle.
- All outputs are registered, or decoded only from state and latched fields. There is no combinational path from m_* inputs to s_* outputs.

## Test plan
- **Word load**: LW 0x00100008; slave1 acks on its first s_req cycle with 0xDEADBEEF. Required: s_addr = 14'h2; m_rvalid two cycles after accept with m_rdata = 0xDEADBEEF and m_err = 0.
- **Byte store**: SB at 0x20000003 with wdata 0x000000A5. Required: s_req = 3'b100, s_wstrb = 4'b1000, s_wdata = 0xA5A5A5A5.
- **Sign and zero extension with wait states**: slave acks after 3 wait cycles with 0x80FF7F01.
  - LB at offset 2 → m_rdata = 0xFFFFFFFF.
  - LBU at offset 3 → m_rdata = 0x00000080.
  - LH at offset 0 → m_rdata = 0x00007F01.
  - Required in each case: m_rvalid 5 cycles after accept.
- **Error cases**:
  - LW 0x00100002 → m_err at T0+1, no s_req.
  - Access to 0x30000000 → m_err at T0+1, no s_req.
  - m_size = 3 → m_err at T0+1, no s_req.
- **Timeout**: a slave that never acks, with TIMEOUT = 15. Required: s_req high for exactly 15 cycles, then m_rvalid = 1 and m_err = 1; an ack on the 15th cycle completes without error.
- **Reset mid-ACCESS**: assert reset 2 cycles into a wait state. Required: at the next edge s_req = 0, m_ready = 1, and no m_rvalid; a subsequent request completes normally.
